// File: rtl/clk_ctrl_pkg.sv
// Shared definitions for the clock divider controller: controller states,
// the smallest legal divide ratio, and the slot numbering used by clk_sel.
package clk_ctrl_pkg;

  typedef enum logic [2:0] {
    BOOT0  = 3'd0,
    BOOT1  = 3'd1,
    IDLE   = 3'd2,
    LOAD   = 3'd3,
    ARM    = 3'd4,
    SWITCH = 3'd5,
    DRAIN  = 3'd6
  } state_e;

  localparam int unsigned MIN_DIV = 2;

  localparam logic SLOT_A = 1'b0;
  localparam logic SLOT_B = 1'b1;

endpackage

// File: rtl/clk_div_ctrl_if.sv
// Request handshake and slot-control bundle of the clock divider controller.
// The master side offers divide ratios; the slave side (the controller)
// drives the two divider slots and the output mux select.
interface clk_div_ctrl_if #(
  parameter int CNT_W = 8
);

  logic             req_valid;
  logic [CNT_W-1:0] req_div;
  logic             req_ready;
  logic             busy;
  logic             err;
  logic [CNT_W-1:0] div_a;
  logic [CNT_W-1:0] div_b;
  logic             en_a;
  logic             en_b;
  logic             slot_rstn_a;
  logic             slot_rstn_b;
  logic             clk_sel;
  logic [CNT_W-1:0] cur_div;

  modport master (
    output req_valid, req_div,
    input  req_ready, busy, err, div_a, div_b, en_a, en_b,
           slot_rstn_a, slot_rstn_b, clk_sel, cur_div
  );

  modport slave (
    input  req_valid, req_div,
    output req_ready, busy, err, div_a, div_b, en_a, en_b,
           slot_rstn_a, slot_rstn_b, clk_sel, cur_div
  );

endinterface

// File: rtl/div_phase_mirror.sv
// Shadow copy of the active divider slot's internal counter. It counts
// 0 .. ratio-1 in lock-step with the slot so the controller knows when the
// slot is about to wrap, which is the only safe moment to hand over.
module div_phase_mirror #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             clear_i,
  input  logic [CNT_W-1:0] ratio_i,
  output logic             wrap_next_o
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign wrap_next_o = (cnt_q == (ratio_i - ONE));

  // Next count: a clear (slot handover) wins, otherwise follow the slot while it is enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = wrap_next_o ? '0 : (cnt_q + ONE);
    end
  end

  // Counter register, cleared together with the rest of the controller.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: run-time controller for the two-slot divided clock.
// A new ratio is loaded into the idle slot, which is then started on the
// same edge the active slot wraps, so the muxed clock never sees a runt.
module clk_div_ctrl
  import clk_ctrl_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int DEF_DIV = 2
) (
  input  logic          clk,
  input  logic          rst,
  clk_div_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] DEF_DIV_W = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0] MIN_DIV_W = CNT_W'(MIN_DIV);

  state_e           state_q, state_d;
  logic             req_ready_q, req_ready_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;
  logic             en_a_q, en_a_d;
  logic             en_b_q, en_b_d;
  logic             rstn_a_q, rstn_a_d;
  logic             rstn_b_q, rstn_b_d;
  logic             clk_sel_q, clk_sel_d;
  logic [CNT_W-1:0] div_a_q, div_a_d;
  logic [CNT_W-1:0] div_b_q, div_b_d;
  logic [CNT_W-1:0] cur_div_q, cur_div_d;
  logic [CNT_W-1:0] new_div_q, new_div_d;

  logic accept;
  logic active_en;
  logic switch_now;
  logic wrap_next;

  assign accept    = bus.req_valid & req_ready_q;
  assign active_en = (clk_sel_q == SLOT_B) ? en_b_q : en_a_q;

  div_phase_mirror #(
    .CNT_W(CNT_W)
  ) u_mirror (
    .clk        (clk),
    .rst        (rst),
    .en_i       (active_en),
    .clear_i    (switch_now),
    .ratio_i    (cur_div_q),
    .wrap_next_o(wrap_next)
  );

  // Sequencer: boot slot A, then on each accepted ratio load the idle slot,
  // wait for the active slot's wrap, swap slots, and finally park the old one.
  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready_q;
    busy_d      = busy_q;
    err_d       = 1'b0;
    en_a_d      = en_a_q;
    en_b_d      = en_b_q;
    rstn_a_d    = rstn_a_q;
    rstn_b_d    = rstn_b_q;
    clk_sel_d   = clk_sel_q;
    div_a_d     = div_a_q;
    div_b_d     = div_b_q;
    cur_div_d   = cur_div_q;
    new_div_d   = new_div_q;
    switch_now  = 1'b0;

    case (state_q)
      BOOT0: begin
        rstn_a_d = 1'b1;
        state_d  = BOOT1;
      end
      BOOT1: begin
        en_a_d      = 1'b1;
        req_ready_d = 1'b1;
        busy_d      = 1'b0;
        state_d     = IDLE;
      end
      IDLE: begin
        if (accept) begin
          if (bus.req_div < MIN_DIV_W) begin
            err_d = 1'b1;
          end else if (bus.req_div != cur_div_q) begin
            new_div_d   = bus.req_div;
            req_ready_d = 1'b0;
            busy_d      = 1'b1;
            state_d     = LOAD;
          end
        end
      end
      LOAD: begin
        if (clk_sel_q == SLOT_A) begin
          div_b_d  = new_div_q;
          rstn_b_d = 1'b1;
        end else begin
          div_a_d  = new_div_q;
          rstn_a_d = 1'b1;
        end
        state_d = ARM;
      end
      ARM: begin
        if (wrap_next) begin
          switch_now = 1'b1;
          if (clk_sel_q == SLOT_A) begin
            en_b_d = 1'b1;
            en_a_d = 1'b0;
          end else begin
            en_a_d = 1'b1;
            en_b_d = 1'b0;
          end
          clk_sel_d = ~clk_sel_q;
          cur_div_d = new_div_q;
          state_d   = SWITCH;
        end
      end
      SWITCH: begin
        state_d = DRAIN;
      end
      DRAIN: begin
        if (clk_sel_q == SLOT_B) begin
          rstn_a_d = 1'b0;
        end else begin
          rstn_b_d = 1'b0;
        end
        req_ready_d = 1'b1;
        busy_d      = 1'b0;
        state_d     = IDLE;
      end
      default: begin
        state_d = BOOT0;
      end
    endcase
  end

  // State and output registers; reset abandons any switch in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= BOOT0;
      req_ready_q <= 1'b0;
      busy_q      <= 1'b1;
      err_q       <= 1'b0;
      en_a_q      <= 1'b0;
      en_b_q      <= 1'b0;
      rstn_a_q    <= 1'b0;
      rstn_b_q    <= 1'b0;
      clk_sel_q   <= SLOT_A;
      div_a_q     <= DEF_DIV_W;
      div_b_q     <= DEF_DIV_W;
      cur_div_q   <= DEF_DIV_W;
      new_div_q   <= DEF_DIV_W;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      en_a_q      <= en_a_d;
      en_b_q      <= en_b_d;
      rstn_a_q    <= rstn_a_d;
      rstn_b_q    <= rstn_b_d;
      clk_sel_q   <= clk_sel_d;
      div_a_q     <= div_a_d;
      div_b_q     <= div_b_d;
      cur_div_q   <= cur_div_d;
      new_div_q   <= new_div_d;
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.busy        = busy_q;
  assign bus.err         = err_q;
  assign bus.en_a        = en_a_q;
  assign bus.en_b        = en_b_q;
  assign bus.slot_rstn_a = rstn_a_q;
  assign bus.slot_rstn_b = rstn_b_q;
  assign bus.clk_sel     = clk_sel_q;
  assign bus.div_a       = div_a_q;
  assign bus.div_b       = div_b_q;
  assign bus.cur_div     = cur_div_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Testbench for clk_div_ctrl: reference model built from the switch timing
// rules, a pair of 50% divider slot models behind the output mux, a table
// of requests, hand-written corner sequences and a randomized run.
module tb_clk_div_ctrl;
  import clk_ctrl_pkg::*;

  localparam int         W   = 8;
  localparam logic [7:0] DEF = 8'd2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  clk_div_ctrl_if #(.CNT_W(W)) ifc ();

  clk_div_ctrl #(.CNT_W(W), .DEF_DIV(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc)
  );

  int total = 0;
  int bad   = 0;

  // reference model state
  int         edgeNo        = 0;
  int         sinceRst      = 0;
  int         enabledCycles = 0;
  int         loadEdge      = -100;
  int         flipEdge      = -100;
  logic       pending       = 1'b0;
  logic       lastAccept    = 1'b0;
  logic [7:0] newN          = DEF;
  logic       mReady = 1'b0, mBusy = 1'b1, mErr = 1'b0;
  logic       mEnA = 1'b0, mEnB = 1'b0, mRstnA = 1'b0, mRstnB = 1'b0, mSel = 1'b0;
  logic [7:0] mDivA = DEF, mDivB = DEF, mCur = DEF;

  // divider slot models fed by the controller outputs
  logic [7:0] cntA = 8'd0;
  logic [7:0] cntB = 8'd0;

  always @(posedge clk) begin
    if (ifc.slot_rstn_a !== 1'b1) cntA <= 8'd0;
    else if (ifc.en_a === 1'b1) cntA <= (cntA == ifc.div_a - 8'd1) ? 8'd0 : cntA + 8'd1;
    if (ifc.slot_rstn_b !== 1'b1) cntB <= 8'd0;
    else if (ifc.en_b === 1'b1) cntB <= (cntB == ifc.div_b - 8'd1) ? 8'd0 : cntB + 8'd1;
  end

  function automatic logic slotOut(input logic [7:0] cnt, input logic [7:0] n);
    return (cnt >= (n - n / 8'd2));
  endfunction

  function automatic logic muxNow();
    return ifc.clk_sel ? slotOut(cntB, ifc.div_b) : slotOut(cntA, ifc.div_a);
  endfunction

  function automatic logic [31:0] actVec();
    return {ifc.req_ready, ifc.busy, ifc.err, ifc.en_a, ifc.en_b,
            ifc.slot_rstn_a, ifc.slot_rstn_b, ifc.clk_sel,
            ifc.div_a, ifc.div_b, ifc.cur_div};
  endfunction

  function automatic logic [31:0] expVec();
    return {mReady, mBusy, mErr, mEnA, mEnB, mRstnA, mRstnB, mSel, mDivA, mDivB, mCur};
  endfunction

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h required %h (edge %0d)", name, act, exp, edgeNo);
    end
  endtask

  // Model of one clock edge, using the inputs present just before it.
  // A switch is scheduled in absolute edge numbers: load one edge after the
  // accept, flip after the active slot's remaining count, done two edges later.
  task automatic modelStep(input logic r, input logic v, input logic [7:0] d);
    logic activeEn;
    int   cur, phase, waitCycles;
    edgeNo++;
    if (r) begin
      mReady = 1'b0; mBusy = 1'b1; mErr = 1'b0;
      mEnA = 1'b0; mEnB = 1'b0; mRstnA = 1'b0; mRstnB = 1'b0; mSel = 1'b0;
      mDivA = DEF; mDivB = DEF; mCur = DEF;
      sinceRst = 0; pending = 1'b0; enabledCycles = 0; lastAccept = 1'b0;
      return;
    end
    activeEn   = mSel ? mEnB : mEnA;
    lastAccept = mReady && v;
    sinceRst++;
    mErr = 1'b0;
    if (activeEn) enabledCycles++;
    if (sinceRst == 1) begin
      mRstnA = 1'b1;
    end else if (sinceRst == 2) begin
      mEnA = 1'b1; mReady = 1'b1; mBusy = 1'b0;
    end else if (pending) begin
      if (edgeNo == loadEdge) begin
        if (!mSel) begin mDivB = newN; mRstnB = 1'b1; end
        else begin mDivA = newN; mRstnA = 1'b1; end
        cur        = int'(mCur);
        phase      = enabledCycles % cur;
        waitCycles = (((cur - 1 - phase) % cur) + cur) % cur;
        flipEdge   = edgeNo + 1 + waitCycles;
      end else if (edgeNo == flipEdge) begin
        if (!mSel) begin mEnB = 1'b1; mEnA = 1'b0; end
        else begin mEnA = 1'b1; mEnB = 1'b0; end
        mSel = ~mSel;
        mCur = newN;
        enabledCycles = 0;
      end else if (edgeNo == flipEdge + 2) begin
        if (mSel) mRstnA = 1'b0;
        else mRstnB = 1'b0;
        mReady = 1'b1; mBusy = 1'b0; pending = 1'b0;
      end
    end else if (lastAccept) begin
      if (int'(d) < int'(MIN_DIV)) begin
        mErr = 1'b1;
      end else if (d != mCur) begin
        pending = 1'b1; newN = d; mReady = 1'b0; mBusy = 1'b1;
        loadEdge = edgeNo + 1; flipEdge = -100;
      end
    end
  endtask

  task automatic applyStimulus(input logic r, input logic v, input logic [7:0] d);
    rst           = r;
    ifc.req_valid = v;
    ifc.req_div   = d;
  endtask

  task automatic checkOutput(input string name);
    compare(name, actVec(), expVec());
  endtask

  task automatic tick();
    logic       r, v;
    logic [7:0] d;
    r = rst; v = ifc.req_valid; d = ifc.req_div;
    @(posedge clk);
    #1;
    modelStep(r, v, d);
    checkOutput("modelCycle");
  endtask

  task automatic waitReady(input string name, input int limit);
    int n;
    n = 0;
    while (ifc.req_ready !== 1'b1 && n < limit) begin
      tick();
      n++;
    end
    total++;
    if (ifc.req_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL %s: req_ready=%b after %0d cycles, required 1", name, ifc.req_ready, n);
    end
  endtask

  typedef struct {
    logic [7:0] div;
    logic       expErr;
    logic       expSwitch;
    logic       expSel;
    logic [7:0] expCur;
  } vec_t;

  vec_t vecs[9];

  localparam logic [31:0] RESET_VEC = {8'b0100_0000, DEF, DEF, DEF};

  initial begin
    logic prevMux;
    logic flipped;
    logic readyDropped;
    int   accepts;
    int   flips;
    logic lastSel;

    vecs[0] = '{8'd1,   1'b1, 1'b0, 1'b1, 8'd5};
    vecs[1] = '{8'd0,   1'b1, 1'b0, 1'b1, 8'd5};
    vecs[2] = '{8'd5,   1'b0, 1'b0, 1'b1, 8'd5};
    vecs[3] = '{8'd2,   1'b0, 1'b1, 1'b0, 8'd2};
    vecs[4] = '{8'd2,   1'b0, 1'b0, 1'b0, 8'd2};
    vecs[5] = '{8'd3,   1'b0, 1'b1, 1'b1, 8'd3};
    vecs[6] = '{8'd255, 1'b0, 1'b1, 1'b0, 8'd255};
    vecs[7] = '{8'd7,   1'b0, 1'b1, 1'b1, 8'd7};
    vecs[8] = '{8'd1,   1'b1, 1'b0, 1'b1, 8'd7};

    // reset and boot
    applyStimulus(1'b1, 1'b0, 8'd0);
    tick();
    tick();
    compare("resetValues", actVec(), RESET_VEC);
    applyStimulus(1'b0, 1'b0, 8'd0);
    tick();
    compare("bootCycle2Ready", 32'(ifc.req_ready), 32'd0);
    tick();
    compare("bootCycle3", {28'd0, ifc.req_ready, ifc.clk_sel, ifc.en_a, ifc.slot_rstn_b}, 32'b1010);
    compare("bootCur", 32'(ifc.cur_div), 32'd2);

    // N = 5 while slot A runs at 2, with the muxed clock watched
    applyStimulus(1'b0, 1'b1, 8'd5);
    tick();
    applyStimulus(1'b0, 1'b0, 8'd0);
    prevMux = muxNow();
    flipped = 1'b0;
    for (int i = 0; i < 20 && !flipped; i++) begin
      prevMux = muxNow();
      tick();
      flipped = (ifc.clk_sel === 1'b1);
    end
    compare("n5Flip", 32'(flipped), 32'd1);
    compare("n5SlotB", {22'd0, ifc.div_b, ifc.en_b, ifc.en_a}, {22'd0, 8'd5, 1'b1, 1'b0});
    compare("n5OldHighBeforeFlip", 32'(prevMux), 32'd1);
    for (int k = 0; k < 10; k++) begin
      compare("n5MuxWave", 32'(muxNow()), 32'((k % 5) >= 3));
      if (k == 1) compare("n5RstnAStillHigh", 32'(ifc.slot_rstn_a), 32'd1);
      if (k == 2) compare("n5RstnALow", {30'd0, ifc.slot_rstn_a, ifc.req_ready}, 32'b01);
      tick();
    end

    // table of single requests
    for (int i = 0; i < 9; i++) begin
      waitReady("vecReady", 600);
      applyStimulus(1'b0, 1'b1, vecs[i].div);
      tick();
      applyStimulus(1'b0, 1'b0, 8'd0);
      compare("vecAcceptCycle", {29'd0, ifc.err, ifc.req_ready, ifc.busy},
              {29'd0, vecs[i].expErr, ~vecs[i].expSwitch, vecs[i].expSwitch});
      tick();
      compare("vecErrPulseEnds", 32'(ifc.err), 32'd0);
      waitReady("vecDone", 600);
      compare("vecResult", {23'd0, ifc.clk_sel, ifc.cur_div}, {23'd0, vecs[i].expSel, vecs[i].expCur});
    end

    // reset while waiting in ARM
    applyStimulus(1'b0, 1'b1, 8'd9);
    tick();
    applyStimulus(1'b0, 1'b0, 8'd0);
    tick();
    compare("armBeforeReset", {22'd0, ifc.busy, ifc.clk_sel, ifc.div_a}, {22'd0, 1'b1, 1'b1, 8'd9});
    applyStimulus(1'b1, 1'b0, 8'd0);
    tick();
    compare("resetInArm", actVec(), RESET_VEC);
    applyStimulus(1'b0, 1'b0, 8'd0);
    tick();
    compare("rebootBoot0", {30'd0, ifc.req_ready, ifc.slot_rstn_a}, 32'b01);
    tick();
    compare("rebootReady", 32'(ifc.req_ready), 32'd1);

    // back-to-back 3 then 4 with req_valid held
    applyStimulus(1'b0, 1'b1, 8'd3);
    accepts = 0; flips = 0; readyDropped = 1'b0; lastSel = ifc.clk_sel;
    for (int i = 0; i < 80 && accepts < 2; i++) begin
      tick();
      if (ifc.clk_sel !== lastSel) flips++;
      lastSel = ifc.clk_sel;
      if (lastAccept) begin
        accepts++;
        if (accepts == 1) ifc.req_div = 8'd4;
        else applyStimulus(1'b0, 1'b0, 8'd0);
      end else if (accepts == 1 && ifc.req_ready === 1'b0) begin
        readyDropped = 1'b1;
      end
    end
    compare("b2bAccepts", 32'(accepts), 32'd2);
    compare("b2bWaitedForReady", 32'(readyDropped), 32'd1);
    applyStimulus(1'b0, 1'b0, 8'd0);
    for (int i = 0; i < 40 && ifc.req_ready !== 1'b1; i++) begin
      tick();
      if (ifc.clk_sel !== lastSel) flips++;
      lastSel = ifc.clk_sel;
    end
    compare("b2bFlips", 32'(flips), 32'd2);
    compare("b2bResult", {23'd0, ifc.clk_sel, ifc.cur_div}, {23'd0, 1'b0, 8'd4});

    // randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      applyStimulus(($urandom_range(0, 199) == 0),
                    1'($urandom_range(0, 1)),
                    ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255))
                                                : 8'($urandom_range(0, 9)));
      tick();
    end
    applyStimulus(1'b0, 1'b0, 8'd0);
    waitReady("randomSettle", 600);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
